// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronizes and debounces three raw coin sensors, queues accepted
// coins, and replays them as spaced single-cycle pulses for vending_machine.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 1,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          nickel_raw,
    input  logic                          dime_raw,
    input  logic                          quarter_raw,
    input  logic                          hold,
    output logic                          nickel,
    output logic                          dime,
    output logic                          quarter,
    output logic                          reject,
    output logic [1:0]                    reject_code,
    output logic [$clog2(FIFO_DEPTH):0]   pending
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   OCC_ZERO = (AW+1)'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam logic [GW-1:0] GAP_ZERO = GW'(0);

    // Channel bit order everywhere: [2] quarter, [1] dime, [0] nickel.
    logic [2:0]             w_raw;
    logic [2:0]             r_sync1;
    logic [2:0]             r_sync2;
    logic [2:0]             r_stable;
    logic [2:0]             r_evt;
    logic [2:0][CW-1:0]     r_cnt;
    logic [2:0][CW-1:0]     w_cnt_nxt;
    logic [2:0]             w_stable_nxt;
    logic [2:0]             w_set;

    logic [2:0]             w_serve;
    logic [1:0]             w_code;
    logic                   w_any;
    logic                   w_full;
    logic                   w_push;
    logic                   w_rej;
    logic                   w_pop;
    logic [1:0]             w_head;

    logic [1:0]             r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;
    logic [GW-1:0]          r_gap;

    logic                   r_nickel;
    logic                   r_dime;
    logic                   r_quarter;
    logic                   r_reject;
    logic [1:0]             r_reject_code;

    assign w_raw = {quarter_raw, dime_raw, nickel_raw};

    // Debounce decision per channel: only a rising stable transition raises an event.
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        w_set        = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_cnt_nxt[i]    = CNT_ZERO;
                    w_stable_nxt[i] = r_sync2[i];
                    w_set[i]        = r_sync2[i];
                end else begin
                    w_cnt_nxt[i]    = r_cnt[i] + CNT_ONE;
                end
            end else begin
                w_cnt_nxt[i] = CNT_ZERO;
            end
        end
    end

    // Synchronizers, debounce state and event latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 3'b000;
            r_sync2  <= 3'b000;
            r_stable <= 3'b000;
            r_cnt    <= {(3*CW){1'b0}};
            r_evt    <= 3'b000;
        end else begin
            r_sync1  <= w_raw;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_nxt;
            r_cnt    <= w_cnt_nxt;
            r_evt    <= (r_evt & ~w_serve) | w_set;
        end
    end

    // Fixed-priority arbiter over the event latches.
    always_comb begin
        w_serve = 3'b000;
        w_code  = 2'b00;
        if (r_evt[2]) begin
            w_serve = 3'b100;
            w_code  = 2'b11;
        end else if (r_evt[1]) begin
            w_serve = 3'b010;
            w_code  = 2'b10;
        end else if (r_evt[0]) begin
            w_serve = 3'b001;
            w_code  = 2'b01;
        end else begin
            w_serve = 3'b000;
            w_code  = 2'b00;
        end
    end

    // Full check deliberately ignores this edge's pop: no bypass into a full queue.
    assign w_any  = |r_evt;
    assign w_full = (r_count == OCC_FULL);
    assign w_push = w_any && !w_full;
    assign w_rej  = w_any && w_full;
    assign w_pop  = (r_count != OCC_ZERO) && !hold && (r_gap == GAP_ZERO);
    assign w_head = r_mem[r_rd_ptr];

    // Coin queue storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 2'b00;
            end
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= OCC_ZERO;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_code;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_ONE;
                2'b01:   r_count <= r_count - OCC_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output pulses, inter-pulse gap counter and reject reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nickel      <= 1'b0;
            r_dime        <= 1'b0;
            r_quarter     <= 1'b0;
            r_gap         <= GAP_ZERO;
            r_reject      <= 1'b0;
            r_reject_code <= 2'b00;
        end else begin
            r_nickel  <= w_pop && (w_head == 2'b01);
            r_dime    <= w_pop && (w_head == 2'b10);
            r_quarter <= w_pop && (w_head == 2'b11);
            if (w_pop) begin
                r_gap <= GAP_LOAD;
            end else if (r_gap != GAP_ZERO) begin
                r_gap <= r_gap - GAP_ONE;
            end else begin
                r_gap <= GAP_ZERO;
            end
            r_reject      <= w_rej;
            r_reject_code <= w_rej ? w_code : 2'b00;
        end
    end

    assign nickel      = r_nickel;
    assign dime        = r_dime;
    assign quarter     = r_quarter;
    assign reject      = r_reject;
    assign reject_code = r_reject_code;
    assign pending     = r_count;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor (D=4, GAP=1, depth 4) with hand-computed edge timing.
module tb_coin_acceptor;

    logic       clk;
    logic       rst_n;
    logic       hold;
    logic [2:0] raw;
    logic       nickel;
    logic       dime;
    logic       quarter;
    logic       reject;
    logic [1:0] reject_code;
    logic [2:0] pending;

    int   edge_no   = 0;
    int   n_vec     = 0;
    int   n_err     = 0;
    int   cnt_n     = 0;
    int   cnt_d     = 0;
    int   cnt_q     = 0;
    int   cnt_rej   = 0;
    int   last_n    = -1;
    int   last_d    = -1;
    int   last_q    = -1;
    logic multi_hot = 1'b0;

    coin_acceptor #(
        .DEBOUNCE_CYCLES (4),
        .GAP_CYCLES      (1),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .nickel_raw  (raw[0]),
        .dime_raw    (raw[1]),
        .quarter_raw (raw[2]),
        .hold        (hold),
        .nickel      (nickel),
        .dime        (dime),
        .quarter     (quarter),
        .reject      (reject),
        .reject_code (reject_code),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    // Pulse monitor: edge_no here is the index of the edge that launched the pulse, plus one.
    always @(negedge clk) begin
        if (nickel) begin
            cnt_n  <= cnt_n + 1;
            last_n <= edge_no;
        end
        if (dime) begin
            cnt_d  <= cnt_d + 1;
            last_d <= edge_no;
        end
        if (quarter) begin
            cnt_q  <= cnt_q + 1;
            last_q <= edge_no;
        end
        if (reject) cnt_rej <= cnt_rej + 1;
        if ((int'(nickel) + int'(dime) + int'(quarter)) > 1) multi_hot <= 1'b1;
    end

    task automatic check_vec(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Returns just after the negedge following relative edge 'rel' (edge 0 = first edge after e0).
    task automatic wait_rel(input int e0, input int rel);
        while (edge_no < e0 + rel + 1) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input int ch);
        int e0;
        e0      = edge_no;
        raw[ch] = 1'b1;
        wait_rel(e0, 5);
        raw[ch] = 1'b0;
        wait_rel(e0, 15);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int n0;
        int d0;
        int q0;

        rst_n = 1'b0;
        hold  = 1'b0;
        raw   = 3'b000;
        repeat (3) @(negedge clk);
        #1;
        check_vec("rst_outs", {nickel, dime, quarter, reject, reject_code}, 0);
        check_vec("rst_pending", pending, 0);
        rst_n = 1'b1;
        e0 = edge_no;
        wait_rel(e0, 4);

        // Single nickel held 10 cycles: push at edge 6, pulse after edge 7.
        n0 = cnt_n;
        e0 = edge_no;
        raw[0] = 1'b1;
        wait_rel(e0, 5);
        check_vec("t1_pend_e5", pending, 0);
        wait_rel(e0, 6);
        check_vec("t1_pend_e6", pending, 1);
        check_vec("t1_nickel_e6", nickel, 0);
        wait_rel(e0, 7);
        check_vec("t1_pend_e7", pending, 0);
        check_vec("t1_nickel_e7", nickel, 1);
        wait_rel(e0, 9);
        raw[0] = 1'b0;
        wait_rel(e0, 30);
        check_vec("t1_count", cnt_n - n0, 1);
        check_vec("t1_edge", last_n - e0 - 1, 7);

        // Three-cycle dime glitch must not be accepted.
        d0 = cnt_d;
        e0 = edge_no;
        raw[1] = 1'b1;
        wait_rel(e0, 2);
        raw[1] = 1'b0;
        wait_rel(e0, 6);
        check_vec("t2_pend_e6", pending, 0);
        wait_rel(e0, 25);
        check_vec("t2_count", cnt_d - d0, 0);
        check_vec("t2_pend_end", pending, 0);

        // Quarter and dime together: quarter after edge 7, dime after edge 9.
        d0 = cnt_d;
        q0 = cnt_q;
        e0 = edge_no;
        raw[2] = 1'b1;
        raw[1] = 1'b1;
        wait_rel(e0, 7);
        check_vec("t3_q_e7", {quarter, dime}, 2);
        check_vec("t3_pend_e7", pending, 1);
        wait_rel(e0, 8);
        check_vec("t3_gap_e8", {quarter, dime}, 0);
        wait_rel(e0, 9);
        check_vec("t3_d_e9", {quarter, dime}, 1);
        check_vec("t3_pend_e9", pending, 0);
        wait_rel(e0, 11);
        raw[2] = 1'b0;
        raw[1] = 1'b0;
        wait_rel(e0, 30);
        check_vec("t3_qcount", cnt_q - q0, 1);
        check_vec("t3_dcount", cnt_d - d0, 1);
        check_vec("t3_qedge", last_q - e0 - 1, 7);
        check_vec("t3_dedge", last_d - e0 - 1, 9);

        // Overflow under hold: four queued, fifth rejected with code 01.
        hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            press(0);
            check_vec($sformatf("t4_pend_%0d", k), pending, k);
        end
        e0 = edge_no;
        raw[0] = 1'b1;
        wait_rel(e0, 5);
        check_vec("t4_rej_e5", reject, 0);
        wait_rel(e0, 6);
        check_vec("t4_rej_e6", reject, 1);
        check_vec("t4_code_e6", reject_code, 1);
        check_vec("t4_pend_e6", pending, 4);
        raw[0] = 1'b0;
        wait_rel(e0, 7);
        check_vec("t4_rej_e7", {reject, reject_code}, 0);
        wait_rel(e0, 20);
        check_vec("t4_rejcount", cnt_rej, 1);

        // Drain: pops at edges 0,2,4,6 after hold release.
        n0 = cnt_n;
        e0 = edge_no;
        hold = 1'b0;
        wait_rel(e0, 0);
        check_vec("t4_drain_n0", nickel, 1);
        check_vec("t4_drain_p0", pending, 3);
        wait_rel(e0, 1);
        check_vec("t4_drain_n1", nickel, 0);
        wait_rel(e0, 6);
        check_vec("t4_drain_p6", pending, 0);
        wait_rel(e0, 15);
        check_vec("t4_drain_count", cnt_n - n0, 4);
        check_vec("t4_drain_last", last_n - e0 - 1, 6);

        // Reset with two coins queued discards them.
        hold = 1'b1;
        press(0);
        press(1);
        check_vec("t5_pend_pre", pending, 2);
        rst_n = 1'b0;
        #1;
        check_vec("t5_pend_rst", pending, 0);
        check_vec("t5_outs_rst", {nickel, dime, quarter, reject, reject_code}, 0);
        n0 = cnt_n;
        d0 = cnt_d;
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        hold  = 1'b0;
        rst_n = 1'b1;
        e0 = edge_no;
        wait_rel(e0, 20);
        check_vec("t5_pend_post", pending, 0);
        check_vec("t5_pulses", (cnt_n - n0) + (cnt_d - d0), 0);

        // Bouncing quarter: single pulse 7 edges after the final rise.
        q0 = cnt_q;
        for (int k = 0; k < 8; k++) begin
            e0 = edge_no;
            raw[2] = ((k % 2) == 0) ? 1'b1 : 1'b0;
            wait_rel(e0, 0);
        end
        e0 = edge_no;
        raw[2] = 1'b1;
        wait_rel(e0, 6);
        check_vec("t6_q_e6", quarter, 0);
        wait_rel(e0, 7);
        check_vec("t6_q_e7", quarter, 1);
        wait_rel(e0, 11);
        raw[2] = 1'b0;
        wait_rel(e0, 30);
        check_vec("t6_count", cnt_q - q0, 1);
        check_vec("t6_edge", last_q - e0 - 1, 7);

        check_vec("multi_hot", multi_hot, 0);
        check_vec("tot_nickel", cnt_n, 5);
        check_vec("tot_reject", cnt_rej, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage that feeds `vending_machine`. It conditions three raw mechanical coin-sensor lines, debounces them, and queues accepted coins. It then emits exactly one single-cycle `nickel`/`dime`/`quarter` pulse per coin, never two in the same cycle, spaced so the downstream FSM sees one coin at a time. Coins that arrive while the queue is full are flagged for return via `reject`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive synchronized samples required to accept a level change; legal values are ≥ 2.
- `GAP_CYCLES`, 1: minimum idle cycles between two output pulses; 0 is legal.
- `FIFO_DEPTH`, 4: coin queue entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `nickel_raw`  in  1  raw 5-cent sensor, asynchronous, active-high, may bounce.
- `dime_raw`  in  1  raw 10-cent sensor, as above.
- `quarter_raw`  in  1  raw 25-cent sensor, as above.
- `hold`  in  1  downstream stall; while high, no coin is popped.
- `nickel`  out  1  one-cycle pulse, 5 cents, to `vending_machine`.
- `dime`  out  1  one-cycle pulse, 10 cents.
- `quarter`  out  1  one-cycle pulse, 25 cents.
- `reject`  out  1  one-cycle pulse: coin dropped because the queue was full.
- `reject_code`  out  2  coin code for `reject` (01 nickel, 10 dime, 11 quarter); 00 when `reject` is low.
- `pending`  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.

## Operation
Per channel, the datapath runs in this order:
- **Synchronizer:** two-flop synchronizer producing `s2`.
- **Debouncer:** counter and `stable` register.
  - On an edge where `s2 != stable`: the counter increments. If the counter already equals `DEBOUNCE_CYCLES-1`, `stable <= s2`, the counter clears, and a rising transition of `stable` sets that channel's event latch.
  - On an edge where `s2 == stable`: the counter clears.
- **Arbiter:** each edge it serves the highest-priority set latch (quarter > dime > nickel) and clears it.
  - If `pending < FIFO_DEPTH`, it pushes the 2-bit coin code.
  - Otherwise it asserts `reject` with that code for one cycle. The full check uses occupancy before that edge's pop; there is no same-cycle bypass.
- **Output stage:**
  - On an edge where the FIFO is non-empty, `hold` is low, and the gap counter is 0, it pops the head.
  - During the following cycle, it drives exactly the matching output high and loads the gap counter with `GAP_CYCLES`.
  - The gap counter decrements to 0 on subsequent edges.
  - At most one of `nickel`/`dime`/`quarter` is high in any cycle.
- **Push and pop on the same edge:** `pending` is unchanged.
- **Latch overrun:** re-triggering a channel needs at least 2×`DEBOUNCE_CYCLES` edges, so a latch is always cleared before it can be set again.
- **Reset:** asserting `rst_n` low at any time clears synchronizers, `stable`, counters, latches, FIFO pointers, and gap counter. Queued coins are discarded.
- **Raw line high at reset release:** `stable` restarts at 0, so a line held high yields one coin after the normal debounce.

## Timing
- **Reset values:** `nickel`, `dime`, `quarter`, `reject` = 0; `reject_code` = 00; `pending` = 0. Outputs go low asynchronously on `rst_n` fall.
- **Latency** (raw high before edge 0 and held, queue empty, `hold` low):
  - edge 0: first sync flop loads.
  - edge 1: `s2` = 1.
  - edges 2..`DEBOUNCE_CYCLES+1`: count; `stable` and the latch set on edge `DEBOUNCE_CYCLES+1`.
  - edge `DEBOUNCE_CYCLES+2`: push.
  - edge `DEBOUNCE_CYCLES+3`: pop; the output pulse is high during the cycle after this edge.
  - With D=4, the pulse is high between edges 7 and 8.
- **Glitch filter:** a high of fewer than `DEBOUNCE_CYCLES` consecutive `s2` samples produces no coin.
- **Back-to-back pulses:** consecutive pulses start `GAP_CYCLES+1` edges apart. With `GAP_CYCLES` = 0, pulses may occur on consecutive cycles.
- **`hold` sampling:** `hold` is sampled at the pop edge. A pulse already driven is not cancelled.
- **`reject` timing:** the pulse coincides with the arbiter edge that would have pushed.

## Test plan
1. **Single coin:** D=4, `GAP_CYCLES`=1, `nickel_raw` high for 10 cycles → exactly one `nickel` pulse, high between edges 7 and 8; `pending` goes 0→1→0.
2. **Glitch:** `dime_raw` high for 3 cycles, then low → no output pulse, `pending` stays 0.
3. **Simultaneous coins:** `quarter_raw` and `dime_raw` rise on the same cycle and are held → `quarter` pulse, then a `dime` pulse 2 edges later; never both high.
4. **Overflow and drain:** `hold`=1, five nickels inserted → `pending` reaches 4 and the fifth gives `reject`=1 with `reject_code`=01 for one cycle. Release `hold` → four `nickel` pulses, 2 edges apart, `pending` 4→0.
5. **Reset mid-operation:** two coins queued under `hold`, then `rst_n` pulsed low with raw lines low → all outputs 0 immediately, `pending`=0, no pulses after release.
6. **Bouncing input:** `quarter_raw` toggles every cycle for 8 cycles, then stays high → exactly one `quarter` pulse, D+3 edges after the last toggle.
